// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared FSM state type, gate truth tables and settle counter width
package gate_sweep_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SAMPLE, DONE} state_t;
  localparam logic [3:0] NAND2_TABLE = 4'b0111;
  localparam logic [3:0] AND2_TABLE  = 4'b1000;
  localparam logic [3:0] OR2_TABLE   = 4'b1110;
  localparam logic [3:0] NOR2_TABLE  = 4'b0001;
  localparam logic [3:0] XOR2_TABLE  = 4'b0110;
  localparam int SETTLE_W = 4;
endpackage

// File: rtl/gate_sweep_timer.sv
// gate_sweep_timer: loadable down-counter with a terminal flag (count == 1)
//   clk, rst_n : clock, synchronous active-low reset
//   i_load     : load i_val (wins over i_en)
//   i_en       : decrement, saturating at 0
//   o_term     : high while the count is 1, i.e. the last wait cycle
module gate_sweep_timer
  import gate_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [SETTLE_W-1:0] i_val,
  input  logic                i_en,
  output logic                o_term
);
  logic [SETTLE_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_term = r_cnt == SETTLE_W'(1);
endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: sweeps a gate's inputs in binary order and checks its output against a truth table
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin sweep (accepted in IDLE/DONE only)
//   dut_in     : gate inputs, MSB = A; dut_out : gate output Y
//   busy, done, pass, err_cnt, fail_vec : sweep status and results
//   Macro GATE_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatch
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int                  N_IN      = 2,
  parameter int                  SETTLE    = 2,
  parameter logic [2**N_IN-1:0]  EXP_TABLE = NAND2_TABLE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N_IN-1:0]     dut_in,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_cnt,
  output logic [2**N_IN-1:0]  fail_vec
);
  localparam logic [N_IN-1:0] LAST = N_IN'(2**N_IN - 1);
  state_t          r_state;
  logic [N_IN-1:0] r_idx;
  logic            w_term;
  logic            w_miss;
  // X/Z on the gate output must count as a failure, hence the 4-state compare
  assign w_miss = dut_out !== EXP_TABLE[r_idx];
  gate_sweep_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (r_state == DRIVE),
    .i_val  (SETTLE_W'(SETTLE)),
    .i_en   (r_state == WAIT),
    .o_term (w_term)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      dut_in   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state  <= DRIVE;
            r_idx    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
          end else if (r_state == DONE) begin
            // err_cnt is final by the time DONE is occupied
            busy <= 1'b0;
            done <= 1'b1;
            pass <= err_cnt == '0;
          end
        end
        DRIVE: begin
          dut_in  <= r_idx;
          r_state <= (SETTLE > 0) ? WAIT : SAMPLE;
        end
        WAIT: if (w_term) r_state <= SAMPLE;
        SAMPLE: begin
          if (w_miss) begin
            err_cnt         <= err_cnt + 1'b1;
            fail_vec[r_idx] <= 1'b1;
          end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
          if (w_miss || r_idx == LAST) r_state <= DONE;
`else
          if (r_idx == LAST) r_state <= DONE;
`endif
          else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= DRIVE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: directed checks of gate_sweep_ctrl with SETTLE=2 and SETTLE=0 instances
module tb_gate_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start0 = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] dut_in, dut_in0;
  logic       dut_out, dut_out0;
  logic       busy, done, pass, busy0, done0, pass0;
  logic [2:0] err_cnt, err_cnt0;
  logic [3:0] fail_vec, fail_vec0;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_in;

  always #5 clk = ~clk;

  // gate model: 0 = NAND, 1 = stuck-at-1, 2 = AND
  assign dut_out  = mode == 2'd0 ? ~&dut_in  : mode == 2'd1 ? 1'b1 : &dut_in;
  assign dut_out0 = mode == 2'd0 ? ~&dut_in0 : mode == 2'd1 ? 1'b1 : &dut_in0;

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(2), .EXP_TABLE(4'b0111)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec)
  );
  gate_sweep_ctrl #(.N_IN(2), .SETTLE(0), .EXP_TABLE(4'b0111)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_in(dut_in0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0), .fail_vec(fail_vec0)
  );

  // start high across exactly one rising edge (edge 0); returns 1 unit after it
  task automatic pulse_start(input bit sel0);
    @(negedge clk);
    if (sel0) start0 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_in !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 3'd0 || fail_vec !== 4'd0) begin
      errors++;
      $display("FAIL reset: in=%0d busy=%b done=%b pass=%b err=%0d fail=%b, want all zero", dut_in, busy, done, pass, err_cnt, fail_vec);
    end
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || err_cnt0 !== 3'd0) begin
      errors++;
      $display("FAIL reset0: busy=%b done=%b err=%0d, want zero", busy0, done0, err_cnt0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_golden;
    mode = 2'd0;
    pulse_start(1'b0);
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk);
      #1;
      exp_in = e > 16 ? 2'd3 : 2'((e - 1) / 4);
      checks++;
      if (dut_in !== exp_in || busy !== (e <= 16) || done !== (e == 17)) begin
        errors++;
        $display("FAIL golden edge %0d: in=%0d busy=%b done=%b, want in=%0d busy=%b done=%b", e, dut_in, busy, done, exp_in, e <= 16, e == 17);
      end
    end
    checks++;
    if (pass !== 1'b1 || err_cnt !== 3'd0 || fail_vec !== 4'b0000) begin
      errors++;
      $display("FAIL golden result: pass=%b err=%0d fail=%b, want 1 0 0000", pass, err_cnt, fail_vec);
    end
  endtask

  task automatic test_stuck1;
    mode = 2'd1;
    pulse_start(1'b0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL stuck1 restart: done=%b busy=%b pass=%b, want 0 1 0", done, busy, pass);
    end
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL stuck1 early done at edge 16: done=%b, want 0", done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || err_cnt !== 3'd1 || fail_vec !== 4'b1000 || pass !== 1'b0) begin
      errors++;
      $display("FAIL stuck1 result: done=%b err=%0d fail=%b pass=%b, want 1 1 1000 0", done, err_cnt, fail_vec, pass);
    end
  endtask

  task automatic test_wrong_gate;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    int         done_edge = 5;
    logic [2:0] exp_err = 3'd1;
    logic [3:0] exp_fail = 4'b0001;
`else
    int         done_edge = 17;
    logic [2:0] exp_err = 3'd4;
    logic [3:0] exp_fail = 4'b1111;
`endif
    mode = 2'd2;
    pulse_start(1'b0);
    for (int e = 1; e <= done_edge; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== (e == done_edge)) begin
        errors++;
        $display("FAIL wrong_gate done at edge %0d: done=%b, want %b", e, done, e == done_edge);
      end
    end
    checks++;
    if (err_cnt !== exp_err || fail_vec !== exp_fail || pass !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrong_gate result: err=%0d fail=%b pass=%b busy=%b, want %0d %b 0 0", err_cnt, fail_vec, pass, busy, exp_err, exp_fail);
    end
  endtask

  task automatic test_busy_start;
    mode = 2'd0;
    pulse_start(1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (dut_in !== 2'd1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL busy_start edge 6: in=%0d busy=%b done=%b, want 1 1 0", dut_in, busy, done);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || dut_in !== 2'd3) begin
      errors++;
      $display("FAIL busy_start edge 16: done=%b in=%0d, want 0 3", done, dut_in);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 3'd0) begin
      errors++;
      $display("FAIL busy_start result: done=%b pass=%b err=%0d, want 1 1 0", done, pass, err_cnt);
    end
  endtask

  task automatic test_reset_mid;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    logic [2:0] exp_err = 3'd1;
`else
    logic [2:0] exp_err = 3'd2;
`endif
    mode = 2'd2;
    pulse_start(1'b0);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (err_cnt !== exp_err) begin
      errors++;
      $display("FAIL reset_mid pre-reset err: err=%0d, want %0d", err_cnt, exp_err);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dut_in !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 3'd0 || fail_vec !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: in=%0d busy=%b done=%b pass=%b err=%0d fail=%b, want all zero", dut_in, busy, done, pass, err_cnt, fail_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2'd0;
    pulse_start(1'b0);
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid rerun early done: done=%b, want 0", done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 3'd0 || fail_vec !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid rerun: done=%b pass=%b err=%0d fail=%b, want 1 1 0 0000", done, pass, err_cnt, fail_vec);
    end
  endtask

  task automatic test_settle0;
    mode = 2'd0;
    for (int run = 0; run < 2; run++) begin
      pulse_start(1'b1);
      for (int e = 1; e <= 9; e++) begin
        @(posedge clk);
        #1;
        exp_in = e > 8 ? 2'd3 : 2'((e - 1) / 2);
        checks++;
        if (done0 !== (e == 9) || dut_in0 !== exp_in) begin
          errors++;
          $display("FAIL settle0 run %0d edge %0d: done=%b in=%0d, want %b %0d", run, e, done0, dut_in0, e == 9, exp_in);
        end
      end
      checks++;
      if (pass0 !== 1'b1 || err_cnt0 !== 3'd0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL settle0 run %0d result: pass=%b err=%0d busy=%b, want 1 0 0", run, pass0, err_cnt0, busy0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_golden;
    test_stuck1;
    test_wrong_gate;
    test_busy_start;
    test_reset_mid;
    test_settle0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
